// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: op codes, widths, state encodings.
// Op decode helpers used by mem_access and load_extend.
package mem_access_pkg;

  localparam int REG_LEN      = 32;
  localparam int ADDR_LEN     = 32;
  localparam int REG_ADDR_LEN = 5;
  localparam int ALU_LEN      = 5;

  localparam logic              RESET_ENABLE = 1'b1;
  localparam logic [REG_LEN-1:0] ZERO_WORD   = '0;

  localparam logic [ALU_LEN-1:0] OP_NO_ALU = 5'h00;
  localparam logic [ALU_LEN-1:0] OP_ADD    = 5'h01;
  localparam logic [ALU_LEN-1:0] OP_LB     = 5'h10;
  localparam logic [ALU_LEN-1:0] OP_LH     = 5'h11;
  localparam logic [ALU_LEN-1:0] OP_LW     = 5'h12;
  localparam logic [ALU_LEN-1:0] OP_LBU    = 5'h13;
  localparam logic [ALU_LEN-1:0] OP_LHU    = 5'h14;
  localparam logic [ALU_LEN-1:0] OP_SB     = 5'h15;
  localparam logic [ALU_LEN-1:0] OP_SH     = 5'h16;
  localparam logic [ALU_LEN-1:0] OP_SW     = 5'h17;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_BUSY,
    MEM_DONE
  } mem_state_e;

  function automatic logic is_load(logic [ALU_LEN-1:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
  endfunction

  function automatic logic is_store(logic [ALU_LEN-1:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

  function automatic logic [2:0] op_bytes(logic [ALU_LEN-1:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 3'd1;
      OP_LH, OP_LHU, OP_SH: return 3'd2;
      OP_LW, OP_SW:         return 3'd4;
      default:              return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// Assembles the little-endian load buffer into a sign/zero-extended word.
// Purely combinational; op selects width and signedness.
module load_extend
  import mem_access_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]  ld_buf,
  input  logic [ALU_LEN-1:0] alu_op,
  output logic [DATA_W-1:0]  result
);

  always_comb begin
    result = '0;
    case (alu_op)
      OP_LB:   result = DATA_W'($signed(ld_buf[7:0]));
      OP_LH:   result = DATA_W'($signed(ld_buf[15:0]));
      OP_LW:   result = DATA_W'($signed(ld_buf[31:0]));
      OP_LBU:  result = DATA_W'(ld_buf[7:0]);
      OP_LHU:  result = DATA_W'(ld_buf[15:0]);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage: byte-serial loads/stores with pipeline stall, MEM/WB drive.
// Define MEM_FWD_EN to add the fwd_* bypass outputs.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst,
`ifdef MEM_FWD_EN
  output logic               fwd_valid,
  output logic [4:0]         fwd_rd_addr,
  output logic [DATA_W-1:0]  fwd_rd_data,
`endif
  input  logic [DATA_W-1:0]  in_rd_data,
  input  logic [4:0]         in_rd_addr,
  input  logic               in_rd_enable,
  input  logic [ADDR_W-1:0]  in_mem_addr,
  input  logic [ALU_LEN-1:0] in_alu_op,
  input  logic [DATA_W-1:0]  in_mem_wdata,
  output logic               mc_req,
  output logic               mc_we,
  output logic [ADDR_W-1:0]  mc_addr,
  output logic [7:0]         mc_wdata,
  input  logic [7:0]         mc_rdata,
  input  logic               mc_ready,
  output logic               stall_req,
  output logic [DATA_W-1:0]  wb_rd_data,
  output logic [4:0]         wb_rd_addr,
  output logic               wb_rd_enable
);

  localparam int LANES = DATA_W / 8;
  localparam int IDX_W = $clog2(LANES);

  mem_state_e        state, state_nx;
  logic [IDX_W-1:0]  idx, idx_nx, n_last;
  logic [DATA_W-1:0] ld_buf, ld_word;
  logic              ld_cap, op_ld, op_st;

  assign op_ld  = is_load(in_alu_op);
  assign op_st  = is_store(in_alu_op);
  assign n_last = IDX_W'(op_bytes(in_alu_op) - 3'd1);

  assign mc_addr  = in_mem_addr + ADDR_W'(idx);
  assign mc_wdata = in_mem_wdata[8*idx +: 8];

  load_extend #(.DATA_W(DATA_W)) u_ext (
    .ld_buf (ld_buf),
    .alu_op (in_alu_op),
    .result (ld_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MEM_IDLE;
      idx    <= '0;
      ld_buf <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      if (ld_cap) ld_buf[8*idx +: 8] <= mc_rdata;
    end
  end

  // Reset forces every output low even before the state register settles.
  always_comb begin
    state_nx     = state;
    idx_nx       = idx;
    ld_cap       = 1'b0;
    mc_req       = 1'b0;
    mc_we        = 1'b0;
    stall_req    = 1'b0;
    wb_rd_enable = 1'b0;
    wb_rd_addr   = '0;
    wb_rd_data   = ZERO_WORD;
    if (!rst) begin
      unique case (state)
        MEM_IDLE: begin
          if (op_ld || op_st) begin
            stall_req  = 1'b1;
            wb_rd_addr = in_rd_addr;
            state_nx   = MEM_BUSY;
            idx_nx     = '0;
          end else begin
            wb_rd_enable = in_rd_enable;
            wb_rd_addr   = in_rd_addr;
            wb_rd_data   = in_rd_data;
          end
        end
        MEM_BUSY: begin
          mc_req     = 1'b1;
          mc_we      = op_st;
          stall_req  = 1'b1;
          wb_rd_addr = in_rd_addr;
          if (mc_ready) begin
            ld_cap = op_ld;
            if (idx == n_last) state_nx = MEM_DONE;
            else idx_nx = idx + 1'b1;
          end
        end
        MEM_DONE: begin
          state_nx   = MEM_IDLE;
          wb_rd_addr = in_rd_addr;
          if (op_ld) begin
            wb_rd_enable = in_rd_enable;
            wb_rd_data   = ld_word;
          end
        end
        default: state_nx = MEM_IDLE;
      endcase
    end
  end

`ifdef MEM_FWD_EN
  assign fwd_valid   = wb_rd_enable && (wb_rd_addr != 5'd0);
  assign fwd_rd_addr = wb_rd_addr;
  assign fwd_rd_data = wb_rd_data;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: byte-level memory responder, transaction model,
// per-cycle compare process and directed load/store/reset vectors.
module tb_mem_access;
  import mem_access_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic [31:0]        in_rd_data;
  logic [4:0]         in_rd_addr;
  logic               in_rd_enable;
  logic [31:0]        in_mem_addr;
  logic [ALU_LEN-1:0] in_alu_op;
  logic [31:0]        in_mem_wdata;
  logic               mc_req, mc_we, mc_ready;
  logic [31:0]        mc_addr;
  logic [7:0]         mc_wdata, mc_rdata;
  logic               stall_req;
  logic [31:0]        wb_rd_data;
  logic [4:0]         wb_rd_addr;
  logic               wb_rd_enable;

  mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_rd_data   (in_rd_data),
    .in_rd_addr   (in_rd_addr),
    .in_rd_enable (in_rd_enable),
    .in_mem_addr  (in_mem_addr),
    .in_alu_op    (in_alu_op),
    .in_mem_wdata (in_mem_wdata),
    .mc_req       (mc_req),
    .mc_we        (mc_we),
    .mc_addr      (mc_addr),
    .mc_wdata     (mc_wdata),
    .mc_rdata     (mc_rdata),
    .mc_ready     (mc_ready),
    .stall_req    (stall_req),
    .wb_rd_data   (wb_rd_data),
    .wb_rd_addr   (wb_rd_addr),
    .wb_rd_enable (wb_rd_enable)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory world: 1 KiB, addresses alias mod 1024.
  logic [7:0] mem [0:1023];
  int  ready_delay = 0;
  int  wait_cnt = 0;
  bit  ready_force = 1'b0;

  assign mc_ready = ready_force || (mc_req && (wait_cnt >= ready_delay));
  assign mc_rdata = mem[mc_addr[9:0]];

  always @(posedge clk) begin
    if (mc_req && mc_ready) begin
      wait_cnt <= 0;
      if (mc_we) mem[mc_addr[9:0]] <= mc_wdata;
    end else if (mc_req) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [7:0]  wd;
  } byte_t;

  byte_t       exp_q[$];
  logic        exp_en = 1'b0;
  logic [4:0]  exp_addr = '0;
  logic [31:0] exp_data = '0;
  bit          chk_on = 1'b0;

  always @(negedge clk) begin
    if (chk_on) begin
      if (rst) begin
        check("rst_mc_req", 32'(mc_req), 32'd0);
        check("rst_stall", 32'(stall_req), 32'd0);
        check("rst_wb_en", 32'(wb_rd_enable), 32'd0);
        check("rst_wb_data", wb_rd_data, 32'd0);
        check("rst_wb_addr", 32'(wb_rd_addr), 32'd0);
      end else begin
        if (mc_req) begin
          if (exp_q.size() == 0) begin
            check("spurious_req", 32'd1, 32'd0);
          end else begin
            check("mc_addr", mc_addr, exp_q[0].addr);
            check("mc_we", 32'(mc_we), 32'(exp_q[0].we));
            if (exp_q[0].we) check("mc_wdata", 32'(mc_wdata), 32'(exp_q[0].wd));
            if (mc_ready) void'(exp_q.pop_front());
          end
        end
        if (stall_req) begin
          check("bubble_en", 32'(wb_rd_enable), 32'd0);
        end else begin
          check("wb_en", 32'(wb_rd_enable), 32'(exp_en));
          if (exp_en) begin
            check("wb_addr", 32'(wb_rd_addr), 32'(exp_addr));
            check("wb_data", wb_rd_data, exp_data);
          end
        end
      end
    end
  end

  task automatic drive_nop();
    in_alu_op    = OP_NO_ALU;
    in_rd_enable = 1'b0;
    in_rd_addr   = '0;
    in_rd_data   = '0;
    in_mem_addr  = '0;
    in_mem_wdata = '0;
    exp_en       = 1'b0;
  endtask

  // Model: byte list, expected result and latency from the op semantics.
  task automatic run_op(input logic [ALU_LEN-1:0] op, input logic [4:0] rd,
                        input logic en, input logic [31:0] data,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int dly, output logic [31:0] got);
    int n, cyc, exp_cyc;
    bit ld, st;
    logic [31:0] v;
    byte_t b;
    ld = (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
         (op == OP_LBU) || (op == OP_LHU);
    st = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) n = 1;
    else if (op == OP_LH || op == OP_LHU || op == OP_SH) n = 2;
    else if (op == OP_LW || op == OP_SW) n = 4;
    else n = 0;
    ready_delay = dly;
    v = '0;
    for (int i = 0; i < n; i++) begin
      b.addr = addr + 32'(i);
      b.we   = st;
      b.wd   = wdata[8*i +: 8];
      exp_q.push_back(b);
      v = v | (32'(mem[b.addr[9:0]]) << (8 * i));
    end
    if (op == OP_LB && v[7])  v = v | 32'hFFFF_FF00;
    if (op == OP_LH && v[15]) v = v | 32'hFFFF_0000;
    exp_en   = (n == 0) ? en : (ld ? en : 1'b0);
    exp_addr = rd;
    exp_data = (n == 0) ? data : v;
    exp_cyc  = (n == 0) ? 1 : n * (dly + 1) + 2;
    in_alu_op    = op;
    in_rd_addr   = rd;
    in_rd_enable = en;
    in_rd_data   = data;
    in_mem_addr  = addr;
    in_mem_wdata = wdata;
    cyc = 0;
    got = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!stall_req) break;
      if (cyc > 200) begin
        check("timeout", 32'd1, 32'd0);
        break;
      end
    end
    got = wb_rd_data;
    check("latency", 32'(cyc), 32'(exp_cyc));
    check("bytes_done", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    drive_nop();
  endtask

  logic [31:0] got;
  byte_t       bb;
  int          cyc;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h100] = 8'h78; mem[10'h101] = 8'h56;
    mem[10'h102] = 8'h34; mem[10'h103] = 8'h12;
    mem[10'h003] = 8'h80;
    mem[10'h020] = 8'h34; mem[10'h021] = 8'hF2;
    mem[10'h3FE] = 8'h11; mem[10'h3FF] = 8'h22;
    mem[10'h000] = 8'h33; mem[10'h001] = 8'h44;
    drive_nop();
    rst    = 1'b1;
    chk_on = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    ready_force = 1'b1;
    run_op(OP_ADD, 5'd5, 1'b1, 32'h1234, 32'h0, 32'h0, 0, got);
    check("add_lit", got, 32'h0000_1234);
    ready_force = 1'b0;

    run_op(OP_LW, 5'd7, 1'b1, 32'h0, 32'h100, 32'h0, 0, got);
    check("lw_lit", got, 32'h1234_5678);
    run_op(OP_LB, 5'd3, 1'b1, 32'h0, 32'h3, 32'h0, 0, got);
    check("lb_lit", got, 32'hFFFF_FF80);
    run_op(OP_LBU, 5'd3, 1'b1, 32'h0, 32'h3, 32'h0, 1, got);
    check("lbu_lit", got, 32'h0000_0080);

    run_op(OP_SH, 5'd9, 1'b1, 32'h0, 32'h1FF, 32'hAABB_CCDD, 3, got);
    check("sh_b0", 32'(mem[10'h1FF]), 32'h0000_00DD);
    check("sh_b1", 32'(mem[10'h200]), 32'h0000_00CC);
    check("sh_b2", 32'(mem[10'h201]), 32'h0000_0000);

    run_op(OP_LH, 5'd4, 1'b1, 32'h0, 32'h20, 32'h0, 0, got);
    check("lh_lit", got, 32'hFFFF_F234);
    run_op(OP_LHU, 5'd4, 1'b1, 32'h0, 32'h20, 32'h0, 2, got);
    check("lhu_lit", got, 32'h0000_F234);
    run_op(OP_LW, 5'd10, 1'b1, 32'h0, 32'hFFFF_FFFE, 32'h0, 0, got);
    check("lw_wrap_lit", got, 32'h4433_2211);

    run_op(OP_SB, 5'd1, 1'b1, 32'h0, 32'h50, 32'h0000_005A, 1, got);
    run_op(OP_LBU, 5'd2, 1'b1, 32'h0, 32'h50, 32'h0, 0, got);
    check("sb_lbu_lit", got, 32'h0000_005A);
    run_op(OP_SW, 5'd1, 1'b1, 32'h0, 32'h61, 32'hCAFE_F00D, 0, got);
    run_op(OP_LW, 5'd11, 1'b1, 32'h0, 32'h61, 32'h0, 1, got);
    check("sw_lw_lit", got, 32'hCAFE_F00D);
    run_op(OP_LW, 5'd12, 1'b0, 32'h0, 32'h100, 32'h0, 0, got);
    run_op(5'h1F, 5'd6, 1'b1, 32'hDEAD, 32'h0, 32'h0, 0, got);
    check("undef_lit", got, 32'h0000_DEAD);

    // Abort an LW while its second byte is pending.
    ready_delay  = 2;
    in_alu_op    = OP_LW;
    in_rd_addr   = 5'd8;
    in_rd_enable = 1'b1;
    in_mem_addr  = 32'h100;
    exp_en       = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bb.addr = 32'h100 + 32'(i);
      bb.we   = 1'b0;
      bb.wd   = 8'h00;
      exp_q.push_back(bb);
    end
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(mc_req && mc_addr == 32'h101) && cyc < 50);
    if (cyc >= 50) check("abort_timeout", 32'd1, 32'd0);
    #1;
    rst = 1'b1;
    #1;
    check("rst_req_now", 32'(mc_req), 32'd0);
    check("rst_wb_now", 32'(wb_rd_enable), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_nop();
    exp_q.delete();
    @(negedge clk);
    check("abort_req", 32'(mc_req), 32'd0);
    check("abort_stall", 32'(stall_req), 32'd0);
    @(posedge clk);
    #1;
    run_op(OP_ADD, 5'd5, 1'b1, 32'h55, 32'h0, 32'h0, 0, got);
    check("post_abort_add", got, 32'h0000_0055);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
